// File: rtl/axil_reg_slice_param_pkg.sv
// ============================================================
// axil_slice_pkg : slice modes, slice state encodings, AXI responses
// Rev 1.0
// ============================================================
`default_nettype none

package axil_slice_pkg;

  typedef enum logic [1:0] {
    SLC_BYPASS = 2'd0,
    SLC_LIGHT  = 2'd1,
    SLC_FULL   = 2'd2
  } slc_mode_e;

  typedef enum logic {
    LT_EMPTY = 1'b0,
    LT_FULL  = 1'b1
  } light_state_e;

  typedef enum logic [1:0] {
    FS_EMPTY = 2'd0,
    FS_ONE   = 2'd1,
    FS_TWO   = 2'd2
  } full_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

`default_nettype wire

// File: rtl/axil_reg_slice_param_if.sv
// ============================================================
// axil_reg_slice_param_if : AXI4-Lite bus bundle with master/slave views
// Rev 1.0
// ============================================================
`default_nettype none

interface axil_reg_slice_param_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

`default_nettype wire

// File: rtl/axil_reg_slice_param_chan_slice.sv
// ============================================================
// axil_chan_slice : one valid/ready channel stage, bypass / light / full skid
// Rev 1.0
// ============================================================
`default_nettype none

module axil_chan_slice
  import axil_slice_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MODE  = 2
) (
  input  logic             clk,
  input  logic             sync_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (MODE == int'(SLC_BYPASS)) begin : g_bypass
    logic w_unused;
    assign w_unused  = &{1'b0, clk, sync_rst_n};
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign out_data  = in_data;
  end else if (MODE == int'(SLC_LIGHT)) begin : g_light
    light_state_e     r_state;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_data;

    // ready is its own flop so it can be held low through reset
    always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
        r_state    <= LT_EMPTY;
        r_in_ready <= 1'b0;
        r_data     <= '0;
      end else begin
        case (r_state)
          LT_EMPTY: begin
            if (in_valid && r_in_ready) begin
              r_state    <= LT_FULL;
              r_data     <= in_data;
              r_in_ready <= 1'b0;
            end else begin
              r_in_ready <= 1'b1;
            end
          end
          LT_FULL: begin
            if (out_ready) begin
              r_state    <= LT_EMPTY;
              r_in_ready <= 1'b1;
            end
          end
          default: begin
            r_state    <= LT_EMPTY;
            r_in_ready <= 1'b0;
          end
        endcase
      end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state == LT_FULL);
    assign out_data  = r_data;
  end else begin : g_full
    full_state_e      r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_in_hs;

    assign w_in_hs = in_valid && r_in_ready;

    // r_main always feeds the output; r_skid catches the beat accepted while stalled
    always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
        r_state     <= FS_EMPTY;
        r_in_ready  <= 1'b0;
        r_out_valid <= 1'b0;
        r_main      <= '0;
        r_skid      <= '0;
      end else begin
        case (r_state)
          FS_EMPTY: begin
            r_in_ready <= 1'b1;
            if (w_in_hs) begin
              r_main      <= in_data;
              r_out_valid <= 1'b1;
              r_state     <= FS_ONE;
            end
          end
          FS_ONE: begin
            if (w_in_hs && !out_ready) begin
              r_skid     <= in_data;
              r_in_ready <= 1'b0;
              r_state    <= FS_TWO;
            end else if (w_in_hs) begin
              r_main <= in_data;
            end else if (out_ready) begin
              r_out_valid <= 1'b0;
              r_state     <= FS_EMPTY;
            end
          end
          FS_TWO: begin
            if (out_ready) begin
              r_main     <= r_skid;
              r_in_ready <= 1'b1;
              r_state    <= FS_ONE;
            end
          end
          default: begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_state     <= FS_EMPTY;
          end
        endcase
      end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
  end

endmodule

`default_nettype wire

// File: rtl/axil_reg_slice_param.sv
// ============================================================
// axil_reg_slice_param : five independent AXI-Lite channel slices
// Optional handshake counters with AXIL_REG_SLICE_STATS_EN.  Rev 1.0
// ============================================================
`default_nettype none

module axil_reg_slice_param
  import axil_slice_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int AW_MODE = int'(SLC_FULL),
  parameter int W_MODE  = int'(SLC_FULL),
  parameter int B_MODE  = int'(SLC_LIGHT),
  parameter int AR_MODE = int'(SLC_FULL),
  parameter int R_MODE  = int'(SLC_FULL)
) (
  input  logic        clk,
  input  logic        sync_rst_n,
`ifdef AXIL_REG_SLICE_STATS_EN
  input  logic        stats_clr,
  output logic [31:0] wr_cnt,
  output logic [31:0] rd_cnt,
`endif
  axil_reg_slice_param_if.slave  s,
  axil_reg_slice_param_if.master m
);

  localparam int c_strb_w = DATA_W / 8;

  logic [DATA_W+c_strb_w-1:0] w_w_out;
  logic [DATA_W+1:0]          w_r_out;

  axil_chan_slice #(.WIDTH(ADDR_W), .MODE(AW_MODE)) u_aw (
    .clk(clk), .sync_rst_n(sync_rst_n),
    .in_valid(s.awvalid), .in_ready(s.awready), .in_data(s.awaddr),
    .out_valid(m.awvalid), .out_ready(m.awready), .out_data(m.awaddr)
  );

  axil_chan_slice #(.WIDTH(DATA_W + c_strb_w), .MODE(W_MODE)) u_w (
    .clk(clk), .sync_rst_n(sync_rst_n),
    .in_valid(s.wvalid), .in_ready(s.wready), .in_data({s.wdata, s.wstrb}),
    .out_valid(m.wvalid), .out_ready(m.wready), .out_data(w_w_out)
  );
  assign {m.wdata, m.wstrb} = w_w_out;

  // response channels run downstream to upstream
  axil_chan_slice #(.WIDTH(2), .MODE(B_MODE)) u_b (
    .clk(clk), .sync_rst_n(sync_rst_n),
    .in_valid(m.bvalid), .in_ready(m.bready), .in_data(m.bresp),
    .out_valid(s.bvalid), .out_ready(s.bready), .out_data(s.bresp)
  );

  axil_chan_slice #(.WIDTH(ADDR_W), .MODE(AR_MODE)) u_ar (
    .clk(clk), .sync_rst_n(sync_rst_n),
    .in_valid(s.arvalid), .in_ready(s.arready), .in_data(s.araddr),
    .out_valid(m.arvalid), .out_ready(m.arready), .out_data(m.araddr)
  );

  axil_chan_slice #(.WIDTH(DATA_W + 2), .MODE(R_MODE)) u_r (
    .clk(clk), .sync_rst_n(sync_rst_n),
    .in_valid(m.rvalid), .in_ready(m.rready), .in_data({m.rdata, m.rresp}),
    .out_valid(s.rvalid), .out_ready(s.rready), .out_data(w_r_out)
  );
  assign {s.rdata, s.rresp} = w_r_out;

`ifdef AXIL_REG_SLICE_STATS_EN
  logic [31:0] r_wr_cnt;
  logic [31:0] r_rd_cnt;

  // clear wins over a same-cycle increment; counters wrap naturally
  always_ff @(posedge clk) begin
    if (!sync_rst_n || stats_clr) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (s.bvalid && s.bready) r_wr_cnt <= r_wr_cnt + 32'd1;
      if (s.rvalid && s.rready) r_rd_cnt <= r_rd_cnt + 32'd1;
    end
  end

  assign wr_cnt = r_wr_cnt;
  assign rd_cnt = r_rd_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axil_reg_slice_param.sv
// ============================================================
// tb_axil_reg_slice_param : directed bench for full, light and bypass slices
// Rev 1.0
// ============================================================
`default_nettype none

module tb_axil_reg_slice_param;
  import axil_slice_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sync_rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc;
  int   mh, sh;
  bit   hs, hit;
  logic [5:0] exp_lt_rdy = 6'b010101;
  logic [5:0] exp_lt_vld = 6'b101010;
  logic [7:0] exp_r_mrdy = 8'b1100_0011;
  logic [7:0] exp_r_svld = 8'b0111_1110;

  axil_reg_slice_param_if #(.ADDR_W(32), .DATA_W(32)) s0 (), m0 (), s1 (), m1 (), s2 (), m2 ();

`ifdef AXIL_REG_SLICE_STATS_EN
  logic        stats_clr;
  logic [31:0] wr_cnt, rd_cnt, wr_cnt1, rd_cnt1, wr_cnt2, rd_cnt2;
`endif

  axil_reg_slice_param u_dut (
    .clk(clk), .sync_rst_n(sync_rst_n),
`ifdef AXIL_REG_SLICE_STATS_EN
    .stats_clr(stats_clr), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt),
`endif
    .s(s0), .m(m0)
  );

  axil_reg_slice_param #(.AW_MODE(1), .W_MODE(1), .B_MODE(1), .AR_MODE(1), .R_MODE(1)) u_lt (
    .clk(clk), .sync_rst_n(sync_rst_n),
`ifdef AXIL_REG_SLICE_STATS_EN
    .stats_clr(1'b0), .wr_cnt(wr_cnt1), .rd_cnt(rd_cnt1),
`endif
    .s(s1), .m(m1)
  );

  axil_reg_slice_param #(.AW_MODE(0), .W_MODE(0), .B_MODE(0), .AR_MODE(0), .R_MODE(0)) u_bp (
    .clk(clk), .sync_rst_n(sync_rst_n),
`ifdef AXIL_REG_SLICE_STATS_EN
    .stats_clr(1'b0), .wr_cnt(wr_cnt2), .rd_cnt(rd_cnt2),
`endif
    .s(s2), .m(m2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] aw_fn(input int i);
    return 32'h4000_0000 + 32'(i) * 32'd4;
  endfunction

  function automatic logic [31:0] wd_fn(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [3:0] ws_fn(input int i);
    return 4'(i) ^ 4'h5;
  endfunction

  task automatic bp_vec(input logic [31:0] a, input logic [31:0] d, input logic v, input logic r);
    s2.awaddr = a;   s2.awvalid = v;  m2.awready = r;
    s2.wdata = d;    s2.wstrb = d[3:0]; s2.wvalid = ~v; m2.wready = ~r;
    m2.bresp = {v, 1'b0}; m2.bvalid = v; s2.bready = r;
    s2.araddr = ~a;  s2.arvalid = v;  m2.arready = r;
    m2.rdata = ~d;   m2.rresp = {r, v}; m2.rvalid = ~v; s2.rready = ~r;
    #1;
    check("bp_aw", {m2.awaddr, m2.awvalid, s2.awready}, {a, v, r});
    check("bp_w",  {m2.wdata, m2.wstrb, m2.wvalid, s2.wready}, {d, d[3:0], ~v, ~r});
    check("bp_b",  {s2.bresp, s2.bvalid, m2.bready}, {v, 1'b0, v, r});
    check("bp_ar", {m2.araddr, m2.arvalid, s2.arready}, {~a, v, r});
    check("bp_r",  {s2.rdata, s2.rresp, s2.rvalid, m2.rready}, {~d, r, v, ~v, ~r});
  endtask

  // n AW and W beats through u_dut, downstream readies low stall% of cycles
  task automatic run_aw_w(input int n, input int stall, input int base, output int cycles);
    int ai = 0, ao = 0, wi = 0, wo = 0;
    bit aw_hold = 0, w_hold = 0, ahi, aho, whi, who;
    cycles = 0;
    while ((ao < n || wo < n) && cycles < 20 * n + 100) begin
      s0.awvalid = (ai < n); s0.awaddr = aw_fn(base + ai);
      s0.wvalid  = (wi < n); s0.wdata = wd_fn(base + wi); s0.wstrb = ws_fn(base + wi);
      m0.awready = ($urandom_range(99) >= stall);
      m0.wready  = ($urandom_range(99) >= stall);
      @(negedge clk);
      if (aw_hold) check("aw_valid_held", m0.awvalid, 1'b1);
      if (w_hold)  check("w_valid_held", m0.wvalid, 1'b1);
      if (m0.awvalid) check("aw_beat", m0.awaddr, aw_fn(base + ao));
      if (m0.wvalid)  check("w_beat", {m0.wdata, m0.wstrb}, {wd_fn(base + wo), ws_fn(base + wo)});
      ahi = s0.awvalid && s0.awready; aho = m0.awvalid && m0.awready;
      whi = s0.wvalid && s0.wready;   who = m0.wvalid && m0.wready;
      aw_hold = m0.awvalid && !m0.awready;
      w_hold  = m0.wvalid && !m0.wready;
      @(posedge clk); #1;
      if (ahi) ai++;
      if (aho) ao++;
      if (whi) wi++;
      if (who) wo++;
      cycles++;
    end
    s0.awvalid = 1'b0; s0.wvalid = 1'b0; m0.awready = 1'b1; m0.wready = 1'b1;
    check("aw_beats_out", ao, n);
    check("w_beats_out", wo, n);
    @(negedge clk);
    check("aw_no_extra", {m0.awvalid, m0.wvalid}, 2'b00);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1);
  end

  initial begin
    sync_rst_n = 1'b0;
    s0.awaddr = '0; s0.awvalid = 0; s0.wdata = '0; s0.wstrb = '0; s0.wvalid = 0; s0.bready = 0; s0.araddr = '0; s0.arvalid = 0; s0.rready = 0;
    s1.awaddr = '0; s1.awvalid = 0; s1.wdata = '0; s1.wstrb = '0; s1.wvalid = 0; s1.bready = 0; s1.araddr = '0; s1.arvalid = 0; s1.rready = 0;
    s2.awaddr = '0; s2.awvalid = 0; s2.wdata = '0; s2.wstrb = '0; s2.wvalid = 0; s2.bready = 0; s2.araddr = '0; s2.arvalid = 0; s2.rready = 0;
    m0.awready = 0; m0.wready = 0; m0.bresp = '0; m0.bvalid = 0; m0.arready = 0; m0.rdata = '0; m0.rresp = '0; m0.rvalid = 0;
    m1.awready = 0; m1.wready = 0; m1.bresp = '0; m1.bvalid = 0; m1.arready = 0; m1.rdata = '0; m1.rresp = '0; m1.rvalid = 0;
    m2.awready = 0; m2.wready = 0; m2.bresp = '0; m2.bvalid = 0; m2.arready = 0; m2.rdata = '0; m2.rresp = '0; m2.rvalid = 0;
`ifdef AXIL_REG_SLICE_STATS_EN
    stats_clr = 1'b0;
`endif

    // reset: valids and readies low, then readies rise one cycle after release
    repeat (3) @(posedge clk);
    #1;
    check("rst_valids", {m0.awvalid, m0.wvalid, s0.bvalid, m0.arvalid, s0.rvalid}, 5'b00000);
    check("rst_readies", {s0.awready, s0.wready, m0.bready, s0.arready, m0.rready}, 5'b00000);
    check("rst_payload", {m0.awaddr, s0.rdata}, 64'h0);
    sync_rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_readies", {s0.awready, s0.wready, m0.bready, s0.arready, m0.rready}, 5'b11111);
    check("post_rst_lt_readies", {s1.awready, s1.wready, m1.bready, s1.arready, m1.rready}, 5'b11111);
`ifdef AXIL_REG_SLICE_STATS_EN
    check("rst_counters", {wr_cnt, rd_cnt}, 64'h0);
`endif

    // bypass: outputs follow inputs in the same cycle
    bp_vec(32'h1234_5678, 32'hA5A5_0F0F, 1'b1, 1'b1);
    bp_vec(32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 1'b0);
    bp_vec(32'h0000_0004, 32'hDEAD_BEEF, 1'b0, 1'b1);

    // light AR: one beat every other cycle with arvalid held high
    s1.arvalid = 1'b1; s1.araddr = 32'h100; m1.arready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("lt_arready", s1.arready, exp_lt_rdy[k]);
      check("lt_m_arvalid", m1.arvalid, exp_lt_vld[k]);
      if (m1.arvalid) check("lt_m_araddr", m1.araddr, 32'h100 + 32'(4 * (k / 2)));
      hs = s1.arvalid && s1.arready;
      @(posedge clk); #1;
      if (hs) s1.araddr = s1.araddr + 32'd4;
    end
    s1.arvalid = 1'b0;

    // full R: two beats land in main+skid while upstream stalls, then drain in order
    for (int c = 0; c < 8; c++) begin
      s0.rready = (c >= 5);
      if (c == 0) begin m0.rvalid = 1'b1; m0.rdata = 32'hDEAD_BEEF; m0.rresp = OKAY; end
      if (c == 1) begin m0.rdata = 32'hCAFE_F00D; m0.rresp = SLVERR; end
      if (c == 2) m0.rvalid = 1'b0;
      @(negedge clk);
      check("r_m_rready", m0.rready, exp_r_mrdy[c]);
      check("r_s_rvalid", s0.rvalid, exp_r_svld[c]);
      if (s0.rvalid) check("r_beat", {s0.rdata, s0.rresp}, (c <= 5) ? {32'hDEAD_BEEF, OKAY} : {32'hCAFE_F00D, SLVERR});
      @(posedge clk); #1;
    end
    s0.rready = 1'b0;

    // full AW/W: unstalled throughput, then randomly stalled stream
    run_aw_w(50, 0, 0, cyc);
    check("aw_w_tput_cycles", cyc, 51);
    run_aw_w(1000, 30, 1000, cyc);

    // reset pulse while R and AW each hold two beats
    m0.rvalid = 1'b1; m0.rdata = 32'h1111_1111; m0.rresp = OKAY; s0.rready = 1'b0;
    s0.awvalid = 1'b1; s0.awaddr = 32'hA0; m0.awready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    m0.rvalid = 1'b0; s0.awvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_two", {s0.rvalid, m0.rready, m0.awvalid, s0.awready}, 4'b1010);
    @(posedge clk); #1;
    sync_rst_n = 1'b0; s0.rready = 1'b1; m0.awready = 1'b1;
    @(posedge clk); #1;
    sync_rst_n = 1'b1;
    @(negedge clk);
    check("pulse_valids", {m0.awvalid, m0.wvalid, s0.bvalid, m0.arvalid, s0.rvalid}, 5'b00000);
    check("pulse_readies", {s0.awready, s0.wready, m0.bready, s0.arready, m0.rready}, 5'b00000);
    check("pulse_payload", {m0.awaddr, s0.rdata}, 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("pulse_readies_up", {s0.awready, s0.wready, m0.bready, s0.arready, m0.rready}, 5'b11111);
    check("pulse_no_stale", {m0.awvalid, s0.rvalid}, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    check("pulse_no_stale2", {m0.awvalid, s0.rvalid}, 2'b00);
    @(posedge clk); #1;

`ifdef AXIL_REG_SLICE_STATS_EN
    // three writes, two reads, then clear on the cycle of a fourth write
    mh = 0; sh = 0;
    m0.bvalid = 1'b1; m0.bresp = OKAY; s0.bready = 1'b1;
    for (int k = 0; k < 30 && sh < 3; k++) begin
      @(negedge clk);
      if (m0.bvalid && m0.bready) mh++;
      if (s0.bvalid && s0.bready) sh++;
      @(posedge clk); #1;
      if (mh == 3) m0.bvalid = 1'b0;
    end
    check("st_b_beats", sh, 3);
    mh = 0; sh = 0;
    m0.rvalid = 1'b1; m0.rdata = 32'h0BAD_F00D; s0.rready = 1'b1;
    for (int k = 0; k < 30 && sh < 2; k++) begin
      @(negedge clk);
      if (m0.rvalid && m0.rready) mh++;
      if (s0.rvalid && s0.rready) sh++;
      @(posedge clk); #1;
      if (mh == 2) m0.rvalid = 1'b0;
    end
    check("st_r_beats", sh, 2);
    check("st_wr_cnt", wr_cnt, 32'd3);
    check("st_rd_cnt", rd_cnt, 32'd2);
    m0.bvalid = 1'b1; m0.bresp = SLVERR; hit = 0; mh = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      @(negedge clk);
      if (s0.bvalid) begin
        hit = 1;
        stats_clr = 1'b1;
        check("st_b4_resp", s0.bresp, SLVERR);
      end
      if (m0.bvalid && m0.bready) mh = 1;
      @(posedge clk); #1;
      if (mh == 1) m0.bvalid = 1'b0;
    end
    stats_clr = 1'b0;
    check("st_b4_seen", hit, 1'b1);
    check("st_clr_counts", {wr_cnt, rd_cnt}, 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
